// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side hazard inputs and pipe-register control outputs.
interface hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic rs1_used_id, rs2_used_id, mem_read_ex, br_taken_ex;
  logic imem_ready, dmem_req_mem, dmem_ready;
  logic stall_if, stall_id, bubble_id, stall_ex, bubble_ex;
  logic stall_mem, bubble_mem, stall_wb, bubble_wb;
  logic [1:0] state_o;
  logic mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  modport master (
    output rs1_id, rs2_id, rd_ex, rs1_used_id, rs2_used_id, mem_read_ex, br_taken_ex,
           imem_ready, dmem_req_mem, dmem_ready,
    input  stall_if, stall_id, bubble_id, stall_ex, bubble_ex, stall_mem, bubble_mem,
           stall_wb, bubble_wb, state_o, mem_err, stall_cnt, flush_cnt
  );
  modport slave (
    input  rs1_id, rs2_id, rd_ex, rs1_used_id, rs2_used_id, mem_read_ex, br_taken_ex,
           imem_ready, dmem_req_mem, dmem_ready,
    output stall_if, stall_id, bubble_id, stall_ex, bubble_ex, stall_mem, bubble_mem,
           stall_wb, bubble_wb, state_o, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: priority hazard resolution, memory-wait timeout FSM and stall/flush statistics.
module hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave h
);
  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam logic [WW-1:0] LAST = WW'(TIMEOUT - 1);
  typedef enum logic [1:0] {RUN = 2'd0, DWAIT = 2'd1, IWAIT = 2'd2} state_t;
  state_t state, cls;
  logic [WW-1:0] wait_cnt;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic mem_err, load_use, ev_d, ev_b, ev_l, ev_i;
  assign load_use = h.mem_read_ex & (h.rd_ex != 5'd0) &
                    ((h.rs1_used_id & (h.rs1_id == h.rd_ex)) | (h.rs2_used_id & (h.rs2_id == h.rd_ex)));
  // One-hot winner of the fixed priority chain
  assign ev_d = h.dmem_req_mem & ~h.dmem_ready;
  assign ev_b = ~ev_d & h.br_taken_ex;
  assign ev_l = ~ev_d & ~h.br_taken_ex & load_use;
  assign ev_i = ~ev_d & ~h.br_taken_ex & ~load_use & ~h.imem_ready;
  always_comb begin
    cls = ev_d ? DWAIT : ev_i ? IWAIT : RUN;
    h.stall_if   = ~rst & (ev_d | ev_l | ev_i);
    h.stall_id   = ~rst & (ev_d | ev_l);
    h.stall_ex   = ~rst & ev_d;
    h.stall_mem  = ~rst & ev_d;
    h.stall_wb   = 1'b0;
    h.bubble_id  = rst | ev_b | ev_i;
    h.bubble_ex  = rst | ev_b | ev_l;
    h.bubble_mem = rst;
    h.bubble_wb  = rst | ev_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= cls;
      wait_cnt <= (cls == RUN) ? '0 : (cls == state) ? wait_cnt + WW'(1) : WW'(1);
      if (cls != RUN && cls == state && wait_cnt == LAST) mem_err <= 1'b1;
      if (h.stall_if && ~&stall_cnt) stall_cnt <= stall_cnt + CNT_W'(1);
      if (ev_b && ~&flush_cnt) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
  assign h.state_o   = state;
  assign h.mem_err   = mem_err;
  assign h.stall_cnt = stall_cnt;
  assign h.flush_cnt = flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random checks of hazard_ctrl against a rule-level reference model.
module tb_hazard_ctrl;
  localparam int TO = 4;
  localparam int CMAX = 7;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0, n_bad = 0;
  int m_state = 0, m_run = 0, m_stall = 0, m_flush = 0;
  bit m_err = 1'b0;
  logic [8:0] ctrl;
  hazard_ctrl_if #(.CNT_W(3)) h ();
  hazard_ctrl #(.TIMEOUT(TO), .CNT_W(3)) dut (.clk(clk), .rst(rst), .h(h));
  always #5 clk = ~clk;
  assign ctrl = {h.stall_if, h.stall_id, h.stall_ex, h.stall_mem, h.stall_wb,
                 h.bubble_id, h.bubble_ex, h.bubble_mem, h.bubble_wb};
  // 0 reset, 1 dmem wait, 2 redirect, 3 load-use, 4 imem wait, 5 none
  function automatic int winner();
    if (rst) return 0;
    if (h.dmem_req_mem && !h.dmem_ready) return 1;
    if (h.br_taken_ex) return 2;
    if (h.mem_read_ex && h.rd_ex != 0 &&
        ((h.rs1_used_id && h.rs1_id == h.rd_ex) || (h.rs2_used_id && h.rs2_id == h.rd_ex))) return 3;
    if (!h.imem_ready) return 4;
    return 5;
  endfunction
  function automatic logic [8:0] exp_ctrl(int w);
    case (w)
      0: return 9'b00000_1111;
      1: return 9'b11110_0001;
      2: return 9'b00000_1100;
      3: return 9'b11000_0100;
      4: return 9'b10000_1000;
      default: return 9'b0;
    endcase
  endfunction
  task automatic quiet();
    h.rs1_id = 5'($urandom); h.rs2_id = 5'($urandom); h.rd_ex = 5'($urandom);
    h.rs1_used_id = 0; h.rs2_used_id = 0; h.mem_read_ex = 0; h.br_taken_ex = 0;
    h.imem_ready = 1; h.dmem_req_mem = 0; h.dmem_ready = 1;
  endtask
  task automatic set_rand();
    h.rs1_id = 5'($urandom_range(3)); h.rs2_id = 5'($urandom_range(3)); h.rd_ex = 5'($urandom_range(3));
    h.rs1_used_id = 1'($urandom); h.rs2_used_id = 1'($urandom); h.mem_read_ex = 1'($urandom);
    h.br_taken_ex = ($urandom_range(5) == 0); h.imem_ready = ($urandom_range(3) != 0);
    h.dmem_req_mem = 1'($urandom); h.dmem_ready = ($urandom_range(2) != 0);
  endtask
  // Advance one edge and apply the behavioural consequences of this cycle's winning event
  task automatic tick();
    int w, c;
    w = winner();
    c = (w == 1) ? 1 : (w == 4) ? 2 : 0;
    @(posedge clk);
    if (rst) begin
      m_state = 0; m_run = 0; m_err = 0; m_stall = 0; m_flush = 0;
    end else begin
      m_run = (c == 0) ? 0 : (c == m_state) ? m_run + 1 : 1;
      if (m_run >= TO) m_err = 1;
      m_state = c;
      if (w == 1 || w == 3 || w == 4) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      if (w == 2) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
    end
    #1;
  endtask
  task automatic reset_dut();
    rst = 1; quiet(); tick(); rst = 0;
  endtask
  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      set_rand(); #1;
      n_vec++;
      if (ctrl !== 9'b00000_1111) begin n_bad++; $display("FAIL reset_ctrl: got %b want %b", ctrl, 9'b00000_1111); end
      tick();
    end
    rst = 0; quiet(); #1;
    n_vec++;
    if ({h.state_o, h.mem_err, h.stall_cnt, h.flush_cnt} !== 9'b0) begin
      n_bad++; $display("FAIL reset_regs: got %b want 0", {h.state_o, h.mem_err, h.stall_cnt, h.flush_cnt});
    end
  endtask
  task automatic test_load_use();
    reset_dut();
    quiet(); h.mem_read_ex = 1; h.rd_ex = 5; h.rs2_used_id = 1; h.rs2_id = 5; #1;
    n_vec++;
    if (ctrl !== 9'b11000_0100) begin n_bad++; $display("FAIL load_use_ctrl: got %b want %b", ctrl, 9'b11000_0100); end
    tick();
    n_vec++;
    if (h.stall_cnt !== 3'd1) begin n_bad++; $display("FAIL load_use_cnt: got %0d want 1", h.stall_cnt); end
    h.rd_ex = 0; h.rs2_id = 0; #1;
    n_vec++;
    if (ctrl !== 9'b0) begin n_bad++; $display("FAIL load_use_x0: got %b want 0", ctrl); end
    tick();
    n_vec++;
    if (h.stall_cnt !== 3'd1) begin n_bad++; $display("FAIL load_use_x0_cnt: got %0d want 1", h.stall_cnt); end
  endtask
  task automatic test_redirect();
    reset_dut();
    quiet(); h.br_taken_ex = 1; h.imem_ready = 0; #1;
    n_vec++;
    if (ctrl !== 9'b00000_1100) begin n_bad++; $display("FAIL redirect_ctrl: got %b want %b", ctrl, 9'b00000_1100); end
    tick();
    n_vec++;
    if ({h.state_o, h.flush_cnt} !== {2'd0, 3'd1}) begin
      n_bad++; $display("FAIL redirect_regs: got state %0d flush %0d want 0 1", h.state_o, h.flush_cnt);
    end
  endtask
  task automatic test_dmem_redirect();
    reset_dut();
    quiet(); h.dmem_req_mem = 1; h.dmem_ready = 0; h.br_taken_ex = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if (ctrl !== 9'b11110_0001) begin n_bad++; $display("FAIL dwait_ctrl: got %b want %b", ctrl, 9'b11110_0001); end
      tick();
      n_vec++;
      if ({h.state_o, h.flush_cnt} !== {2'd1, 3'd0}) begin
        n_bad++; $display("FAIL dwait_regs: got state %0d flush %0d want 1 0", h.state_o, h.flush_cnt);
      end
    end
    h.dmem_ready = 1; #1;
    n_vec++;
    if (ctrl !== 9'b00000_1100) begin n_bad++; $display("FAIL dwait_release: got %b want %b", ctrl, 9'b00000_1100); end
    tick();
    n_vec++;
    if ({h.state_o, h.flush_cnt} !== {2'd0, 3'd1}) begin
      n_bad++; $display("FAIL dwait_release_regs: got state %0d flush %0d want 0 1", h.state_o, h.flush_cnt);
    end
  endtask
  task automatic test_timeout();
    reset_dut();
    quiet(); h.imem_ready = 0;
    for (int i = 0; i < 3; i++) tick();
    h.imem_ready = 1; tick();
    n_vec++;
    if (h.mem_err !== 1'b0) begin n_bad++; $display("FAIL timeout_3: got %b want 0", h.mem_err); end
    h.imem_ready = 0;
    for (int i = 0; i < 3; i++) tick();
    n_vec++;
    if (h.mem_err !== 1'b0) begin n_bad++; $display("FAIL timeout_early: got %b want 0", h.mem_err); end
    tick();
    n_vec++;
    if (h.mem_err !== 1'b1) begin n_bad++; $display("FAIL timeout_4: got %b want 1", h.mem_err); end
    h.imem_ready = 1; tick(); tick();
    n_vec++;
    if (h.mem_err !== 1'b1) begin n_bad++; $display("FAIL timeout_sticky: got %b want 1", h.mem_err); end
    reset_dut();
    quiet(); h.imem_ready = 0; tick(); tick();
    h.imem_ready = 1; h.dmem_req_mem = 1; h.dmem_ready = 0; tick(); tick();
    n_vec++;
    if ({h.state_o, h.mem_err} !== {2'd1, 1'b0}) begin
      n_bad++; $display("FAIL timeout_mixed: got state %0d err %b want 1 0", h.state_o, h.mem_err);
    end
    reset_dut();
    quiet(); h.imem_ready = 0;
    for (int i = 0; i < 3; i++) tick();
    rst = 1; tick(); rst = 0; tick();
    n_vec++;
    if (h.mem_err !== 1'b0) begin n_bad++; $display("FAIL timeout_rst_mid: got %b want 0", h.mem_err); end
  endtask
  task automatic test_saturation();
    reset_dut();
    quiet(); h.imem_ready = 0;
    for (int i = 0; i < 10; i++) tick();
    n_vec++;
    if (h.stall_cnt !== 3'd7) begin n_bad++; $display("FAIL saturation: got %0d want 7", h.stall_cnt); end
  endtask
  task automatic test_random();
    logic [8:0] e;
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      set_rand();
      if (i % 40 == 20) begin h.imem_ready = 0; h.dmem_req_mem = 0; h.br_taken_ex = 0; h.mem_read_ex = 0; end
      rst = ($urandom_range(59) == 0);
      #1;
      e = exp_ctrl(winner());
      n_vec++;
      if (ctrl !== e) begin n_bad++; $display("FAIL rand_ctrl[%0d]: got %b want %b", i, ctrl, e); end
      tick();
      n_vec++;
      if ({h.state_o, h.mem_err, h.stall_cnt, h.flush_cnt} !== {2'(m_state), m_err, 3'(m_stall), 3'(m_flush)}) begin
        n_bad++;
        $display("FAIL rand_regs[%0d]: got %b want %b", i, {h.state_o, h.mem_err, h.stall_cnt, h.flush_cnt},
                 {2'(m_state), m_err, 3'(m_stall), 3'(m_flush)});
      end
    end
    rst = 0;
  endtask
  initial begin
    quiet();
    test_reset();
    test_load_use();
    test_redirect();
    test_dmem_redirect();
    test_timeout();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
